// File: rtl/ex_muldiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and
// FSM state encodings.
package ex_muldiv_iter_pkg;

  typedef enum logic {
    MD_OP_MULT = 1'b0,
    MD_OP_DIV  = 1'b1
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_iter_md_step.sv
// One combinational iteration of the multiply/divide datapath: a shift-add
// step for MULT or a restoring trial-subtract step for DIV, on magnitudes.
module ex_muldiv_iter_md_step
  import ex_muldiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Remainder shifted left with the next dividend bit; WIDTH+1 bits wide.
    shifted = {hi, lo[WIDTH-1]};
    trial   = shifted - {1'b0, operand};
    hi_next = '0;
    lo_next = '0;
    if (op == MD_OP_MULT) begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

endmodule

// File: rtl/ex_muldiv_iter.sv
// Multi-cycle signed/unsigned multiply/divide unit beside the EX-stage ALU.
// Holds the FSM, iteration counter, operand/sign capture and result registers.
module ex_muldiv_iter
  import ex_muldiv_iter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit FAST_MULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             op_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        state_reg, state_next;
  logic [CW-1:0]    count_reg;
  md_op_e           op_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] work_hi_reg, work_lo_reg, operand_reg;
  logic             busy_reg, done_reg, div_zero_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             accept, finish, is_fast, div_by_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] fast_prod;

  assign a_neg       = signed_i & opa_i[WIDTH-1];
  assign b_neg       = signed_i & opb_i[WIDTH-1];
  assign mag_a       = a_neg ? -opa_i : opa_i;
  assign mag_b       = b_neg ? -opb_i : opb_i;
  assign div_by_zero = (opb_i == '0);
  assign is_fast     = (op_i == MD_OP_DIV) ? div_by_zero : FAST_MULT;

  // Sign-extended operands make one truncated product correct for both signednesses.
  generate
    if (FAST_MULT) begin : g_fast_mult
      logic [2*WIDTH-1:0] ext_a, ext_b;
      assign ext_a     = {{WIDTH{a_neg}}, opa_i};
      assign ext_b     = {{WIDTH{b_neg}}, opb_i};
      assign fast_prod = ext_a * ext_b;
    end else begin : g_iter_mult
      assign fast_prod = '0;
    end
  endgenerate

  ex_muldiv_iter_md_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_reg),
    .hi      (work_hi_reg),
    .lo      (work_lo_reg),
    .operand (operand_reg),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      MD_IDLE, MD_DONE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = is_fast ? MD_DONE : MD_BUSY;
        end else begin
          state_next = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (count_reg == LAST) begin
          finish     = 1'b1;
          state_next = MD_DONE;
        end
      end
      default: state_next = MD_IDLE;
    endcase
    if (annul_i) begin
      state_next = MD_IDLE;
      accept     = 1'b0;
      finish     = 1'b0;
    end
  end

  // Sign fix-up applied to the final iteration's magnitudes.
  always_comb begin
    product = {step_hi, step_lo};
    res_hi  = step_hi;
    res_lo  = step_lo;
    if (op_reg == MD_OP_MULT) begin
      if (neg_q_reg) product = -product;
      res_hi = product[2*WIDTH-1:WIDTH];
      res_lo = product[WIDTH-1:0];
    end else begin
      res_lo = neg_q_reg ? -step_lo : step_lo;
      res_hi = neg_r_reg ? -step_hi : step_hi;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MD_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == MD_BUSY);
      done_reg  <= (state_next == MD_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg    <= '0;
      op_reg       <= MD_OP_MULT;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      work_hi_reg  <= '0;
      work_lo_reg  <= '0;
      operand_reg  <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else if (accept) begin
      count_reg   <= '0;
      op_reg      <= md_op_e'(op_i);
      neg_q_reg   <= a_neg ^ b_neg;
      neg_r_reg   <= a_neg;
      work_hi_reg <= '0;
      work_lo_reg <= (op_i == MD_OP_DIV) ? mag_a : mag_b;
      operand_reg <= (op_i == MD_OP_DIV) ? mag_b : mag_a;
      if (op_i == MD_OP_DIV && div_by_zero) begin
        hi_reg       <= opa_i;
        lo_reg       <= '1;
        div_zero_reg <= 1'b1;
      end else if (op_i == MD_OP_MULT && FAST_MULT) begin
        hi_reg       <= fast_prod[2*WIDTH-1:WIDTH];
        lo_reg       <= fast_prod[WIDTH-1:0];
        div_zero_reg <= 1'b0;
      end
    end else if (state_reg == MD_BUSY) begin
      count_reg   <= count_reg + CW'(1);
      work_hi_reg <= step_hi;
      work_lo_reg <= step_lo;
      if (finish) begin
        hi_reg       <= res_hi;
        lo_reg       <= res_lo;
        div_zero_reg <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_reg;
  assign done_o     = done_reg;
  assign hi_o       = hi_reg;
  assign lo_o       = lo_reg;
  assign div_zero_o = div_zero_reg;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Self-checking bench for ex_muldiv_iter: an iterative and a fast-multiply
// instance checked against an arithmetic reference model.
module tb_ex_muldiv_iter;

  localparam int W = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic start_i = 1'b0, start_f = 1'b0;
  logic op_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
  logic [W-1:0] opa_i = '0, opb_i = '0;
  logic busy_s, done_s, dz_s, busy_f, done_f, dz_f;
  logic [W-1:0] hi_s, lo_s, hi_f, lo_f;
  int total = 0, fails = 0;
  logic [2*W-1:0] last_s = '0;

  always #5 clk = ~clk;

  ex_muldiv_iter #(.WIDTH(W), .FAST_MULT(1'b0)) dut_s (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .signed_i(signed_i),
    .annul_i(annul_i), .opa_i(opa_i), .opb_i(opb_i), .busy_o(busy_s),
    .done_o(done_s), .hi_o(hi_s), .lo_o(lo_s), .div_zero_o(dz_s)
  );

  ex_muldiv_iter #(.WIDTH(W), .FAST_MULT(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start_i(start_f), .op_i(op_i), .signed_i(signed_i),
    .annul_i(annul_i), .opa_i(opa_i), .opb_i(opb_i), .busy_o(busy_f),
    .done_o(done_f), .hi_o(hi_f), .lo_o(lo_f), .div_zero_o(dz_f)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic void ref_model(input bit op, input bit sgn, input logic [W-1:0] a,
                                    input logic [W-1:0] b, output logic [W-1:0] hi,
                                    output logic [W-1:0] lo, output logic dz);
    longint sa, sb;
    logic [63:0] p;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    dz = 1'b0;
    if (!op) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == '0) begin
      hi = a;
      lo = '1;
      dz = 1'b1;
    end else begin
      lo = 32'(sa / sb);
      hi = 32'(sa % sb);
    end
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic drive(input bit f, input bit op, input bit sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op_i = op; signed_i = sgn; opa_i = a; opb_i = b; annul_i = 1'b0;
    if (f) start_f = 1'b1; else start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; start_f = 1'b0;
  endtask

  task automatic wait_done(input bit f, output int n, output int nb);
    n = 0; nb = 0;
    while (n < 3*W) begin
      if (f ? done_f : done_s) break;
      if (f ? busy_f : busy_s) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input bit f, input bit op, input bit sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string tag);
    logic [W-1:0] eh, el;
    logic edz;
    int n, nb, lat;
    ref_model(op, sgn, a, b, eh, el, edz);
    lat = ((!op && f) || (op && b == '0)) ? 0 : W;
    drive(f, op, sgn, a, b);
    wait_done(f, n, nb);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " busy cycles"}, 64'(nb), 64'(lat));
    check({tag, " hi:lo"}, f ? {hi_f, lo_f} : {hi_s, lo_s}, {eh, el});
    check({tag, " div_zero"}, 64'(f ? dz_f : dz_s), 64'(edz));
    $display("%s: %s sgn=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d", tag,
             op ? "DIV " : "MULT", sgn, a, b, f ? hi_f : hi_s, f ? lo_f : lo_s,
             f ? dz_f : dz_s, n);
    if (!f) last_s = {eh, el};
    @(negedge clk);
    check({tag, " done pulse"}, 64'(f ? done_f : done_s), 64'd0);
  endtask

  initial begin
    int n, nb, dones;
    logic [W-1:0] eh, el, ra, rb;
    logic edz;
    bit rop, rsg, rf;

    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy_s), 64'd0);
    check("reset done", 64'(done_s), 64'd0);
    check("reset hi:lo", {hi_s, lo_s}, 64'd0);
    check("reset div_zero", 64'(dz_s), 64'd0);
    check("reset fast busy/done", 64'({busy_f, done_f}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b0, 1'b0, 1'b1, 32'hFFFFFFFB, 32'd3, "t1 mult iter");
    do_op(1'b1, 1'b0, 1'b1, 32'hFFFFFFFB, 32'd3, "t1 mult fast");
    do_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, "t2 div 100/7");
    do_op(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, "t3 div -7/2");
    do_op(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, "t3 div MIN/-1");
    do_op(1'b0, 1'b1, 1'b0, 32'h12345678, 32'd0, "t4 div by zero");

    // Annul an in-flight divide; results must hold and a new start must be taken.
    drive(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h1234);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("t5 annul busy", 64'(busy_s), 64'd0);
    check("t5 annul done", 64'(done_s), 64'd0);
    check("t5 annul hi:lo held", {hi_s, lo_s}, last_s);
    do_op(1'b0, 1'b1, 1'b1, 32'hFFFF0000, 32'd77, "t5 start after annul");

    // annul with start in the same cycle: nothing accepted
    op_i = 1'b1; signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd5;
    start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    check("t5 annul+start busy", 64'(busy_s), 64'd0);
    dones = 0;
    repeat (W + 2) begin
      if (done_s) dones++;
      @(negedge clk);
    end
    check("t5 annul+start no done", 64'(dones), 64'd0);
    check("t5 annul+start hi:lo held", {hi_s, lo_s}, last_s);

    // start in BUSY ignored, start in DONE accepted
    ref_model(1'b1, 1'b0, 32'd1000, 32'd3, eh, el, edz);
    drive(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    op_i = 1'b0; opa_i = 32'd7; opb_i = 32'd9; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(1'b0, n, nb);
    check("t6 busy-start latency", 64'(n), 64'(W - 6));
    check("t6 busy-start hi:lo", {hi_s, lo_s}, {eh, el});
    $display("t6 busy-start: DIV 1000/3 -> hi=%h lo=%h lat=%0d", hi_s, lo_s, n);
    do_op(1'b0, 1'b0, 1'b1, 32'd12345, 32'hFFFFFD5A, "t6 start in DONE");

    // async reset mid-operation clears outputs before the next edge
    drive(1'b0, 1'b1, 1'b0, 32'd999, 32'd4);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6 rst busy", 64'(busy_s), 64'd0);
    check("t6 rst done", 64'(done_s), 64'd0);
    check("t6 rst hi:lo", {hi_s, lo_s}, 64'd0);
    check("t6 rst fast hi:lo", {hi_f, lo_f}, 64'd0);
    check("t6 rst div_zero", 64'(dz_s), 64'd0);
    $display("t6 reset mid-busy applied");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rop = 1'($urandom_range(0, 1));
      rsg = 1'($urandom_range(0, 1));
      rf  = (i % 3 == 0);
      ra  = (i % 7 == 3) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'($urandom);
        default: rb = '1;
      endcase
      do_op(rf, rop, rsg, ra, rb, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
